md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Parametrised multiply/divide unit for the E stage of the pipelined MIPS core.
- Executes mult/multu/div/divu over a configurable multi-cycle latency.
- Holds the HI/LO registers and services mthi/mtlo writes.
- Generates the D-stage stall request for any multiply/divide-class instruction while the unit is occupied. This replaces the purely combinational stall flag used today.

Parameters:
- WIDTH, 32: operand and HI/LO width in bits.
- MULT_CYCLES, 5: busy cycles for mult/multu; legal range 1..63.
- DIV_CYCLES, 10: busy cycles for div/divu; legal range 1..63.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  E-stage instruction is a valid md operation this cycle.
- md_op  input  3  operation: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu (6/7 exist only with the optional feature).
- rs_val  input  WIDTH  forwarded rs operand.
- rt_val  input  WIDTH  forwarded rt operand.
- d_md  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo/madd/maddu.
- busy  output  1  multi-cycle operation in progress.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- stall  output  1  D-stage stall request.

Behaviour:
- Reset (async, reset==0): busy=0, hi=0, lo=0, counter=0, operand latches cleared. Takes effect immediately.
- Reset mid-operation aborts the operation with no HI/LO update.
- Two states, IDLE and RUN; the counter width is enough to hold max(MULT_CYCLES, DIV_CYCLES).
- IDLE, start, md_op in 0..3 (and 6/7 when enabled):
  - Latch rs_val, rt_val and md_op.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; busy=1 from the next edge.
- RUN: counter decrements each edge. On the edge where it reaches 0:
  - Write the result to HI/LO.
  - busy=0.
  - Go to IDLE.
  - Net effect: busy is high for exactly N cycles and the new HI/LO is visible in the cycle busy falls.
- mthi/mtlo in IDLE: write rs_val to hi or lo on the next edge. busy stays 0.
- Any start (including mthi/mtlo) while busy=1 is ignored. The stall guarantees this does not occur in normal flow.
- Results before WIDTH truncation:
  - mult: signed 2*WIDTH product; hi=upper half, lo=lower half.
  - multu: same as mult, but unsigned.
  - div: signed, quotient truncated toward zero; lo=quotient, hi=remainder (remainder takes the sign of the dividend).
  - divu: unsigned; lo=quotient, hi=remainder.
- Divide by zero: the full busy period still runs, and HI/LO stay unchanged.
- Signed overflow (most-negative / -1): lo=most-negative, hi=0.
- Operand inputs changing during RUN have no effect; only the latched values are used.
- stall = d_md & (busy | (start & md_op is a multi-cycle op)). Purely combinational from the current-cycle state.
- stall is 0 in reset and whenever d_md=0.
- hi and lo are always driven directly from registers, with no combinational path from the inputs.

Optional Feature:
- Macro: MD_UNIT_MADD_EN.
- When defined:
  - md_op 6 (madd, signed) and 7 (maddu, unsigned) take MULT_CYCLES.
  - On completion, {hi,lo} = {hi,lo} + product, modulo 2^(2*WIDTH).
  - The HI/LO values used are the ones present at completion.
- When undefined:
  - md_op 6/7 are treated as no-ops: no busy, no HI/LO change.
  - They do not contribute to stall via start.

Test Plan:
- reset=0 pulse mid-clock with busy=1 → immediately busy=0, hi=0, lo=0. After release, a new mult runs normally.
- mult rs=0xFFFFFFFE (−2), rt=3:
  - busy high for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - Repeat with multu: hi=0x00000002, lo=0xFFFFFFFA.
- div rs=−7 (0xFFFFFFF9), rt=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 with prior hi=0x11, lo=0x22 → values unchanged after 10 cycles.
- d_md=1 held while div starts:
  - stall=1 in the start cycle and throughout all 10 busy cycles.
  - stall=0 in the cycle busy falls.
  - stall=0 throughout if d_md=0.
- mthi rs=0xABCD with start while busy=1 → ignored (hi unchanged). Same op when idle → hi=0xABCD next edge, busy stays 0.
- With MD_UNIT_MADD_EN defined: hi=0, lo=0xFFFFFFFF, then maddu rs=1, rt=1 → hi=1, lo=0 after 5 cycles. With the macro undefined the same op leaves HI/LO unchanged and busy=0.

Source files
------------

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding HI/LO, with D-stage stall generation.
// Optional madd/maddu support is enabled by defining MD_UNIT_MADD_EN.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             d_md,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             stall
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MADDU = 3'd7;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state, next_state;
    logic [CW-1:0]    count;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;

    logic             op_multi, accept, done;
    logic [CW-1:0]    load_val;

    always_comb begin
        op_multi = (md_op <= OP_DIVU);
`ifdef MD_UNIT_MADD_EN
        op_multi = op_multi | (md_op == OP_MADD) | (md_op == OP_MADDU);
`endif
        accept   = (state == IDLE) & start & op_multi;
        done     = (state == RUN) & (count == CNT_ONE);
        load_val = (md_op == OP_DIV || md_op == OP_DIVU) ? DIV_LOAD : MULT_LOAD;
    end

    // Arithmetic works only on the latched operands, never on the live inputs.
    logic [2*WIDTH-1:0] prod_s, prod_u, result;
    logic [WIDTH-1:0]   mag_a, mag_b, div_s, div_u;
    logic [WIDTH-1:0]   q_mag, r_mag, q_s, r_s, q_u, r_u;
    logic               a_neg, b_neg, b_zero;

    always_comb begin
        prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
        prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        a_neg  = a_q[WIDTH-1];
        b_neg  = b_q[WIDTH-1];
        b_zero = (b_q == '0);
        mag_a  = a_neg ? -a_q : a_q;
        mag_b  = b_neg ? -b_q : b_q;
        // Zero divisor is replaced so the dividers never see it; the result is discarded.
        div_s  = b_zero ? ONE_W : mag_b;
        div_u  = b_zero ? ONE_W : b_q;
        q_mag  = mag_a / div_s;
        r_mag  = mag_a % div_s;
        q_s    = (a_neg ^ b_neg) ? -q_mag : q_mag;
        r_s    = a_neg ? -r_mag : r_mag;
        q_u    = a_q / div_u;
        r_u    = a_q % div_u;

        result = {hi_q, lo_q};
        case (op_q)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV:   if (!b_zero) result = {r_s, q_s};
            OP_DIVU:  if (!b_zero) result = {r_u, q_u};
`ifdef MD_UNIT_MADD_EN
            OP_MADD:  result = {hi_q, lo_q} + prod_s;
            OP_MADDU: result = {hi_q, lo_q} + prod_u;
`endif
            default:  result = {hi_q, lo_q};
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                count <= load_val;
                op_q  <= md_op;
                a_q   <= rs_val;
                b_q   <= rt_val;
            end else if (state == RUN) begin
                count <= count - CNT_ONE;
            end
            if (done) begin
                {hi_q, lo_q} <= result;
            end else if (state == IDLE && start && md_op == OP_MTHI) begin
                hi_q <= rs_val;
            end else if (state == IDLE && start && md_op == OP_MTLO) begin
                lo_q <= rs_val;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = RUN;
            RUN:     if (done)   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // busy is the state bit itself; stall is masked while reset is asserted.
    always_comb begin
        busy  = (state == RUN);
        stall = reset & d_md & (busy | (start & op_multi));
        hi    = hi_q;
        lo    = lo_q;
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: table of single operations plus stall, ignore,
// and reset-abort sequences. Honours MD_UNIT_MADD_EN for madd expectations.
module tb_md_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   md_op;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         d_md;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         stall;

    md_unit #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .d_md   (d_md),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .stall  (stall)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        int          e_cyc;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    // Issue one op at a negedge, then count busy cycles until it falls.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        @(negedge clk);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        start  = 1'b0;
        rs_val = $urandom;
        rt_val = $urandom;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc;
        bit ok;

        vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{3'd3, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
        vecs[4]  = '{3'd4, 32'h11,       32'd0,        32'h00000011, 32'h00000003, 0};
        vecs[5]  = '{3'd5, 32'h22,       32'd0,        32'h00000011, 32'h00000022, 0};
        vecs[6]  = '{3'd3, 32'd7,        32'd0,        32'h00000011, 32'h00000022, 10};
        vecs[7]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[8]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[9]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[10] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[11] = '{3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFE, 32'h00000001, 10};
        vecs[12] = '{3'd4, 32'h0,        32'd0,        32'h00000000, 32'h00000001, 0};
        vecs[13] = '{3'd5, 32'hFFFFFFFF, 32'd0,        32'h00000000, 32'hFFFFFFFF, 0};
`ifdef MD_UNIT_MADD_EN
        vecs[14] = '{3'd7, 32'd1,        32'd1,        32'h00000001, 32'h00000000, 5};
        vecs[15] = '{3'd6, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 5};
`else
        vecs[14] = '{3'd7, 32'd1,        32'd1,        32'h00000000, 32'hFFFFFFFF, 0};
        vecs[15] = '{3'd6, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 0};
`endif

        // Reset state, with stall inputs asserted to prove stall is masked.
        reset  = 1'b0;
        start  = 1'b1;
        md_op  = 3'd0;
        rs_val = 32'h1234;
        rt_val = 32'h5678;
        d_md   = 1'b1;
        #12;
        check("reset_busy",  busy,  0);
        check("reset_hi",    hi,    0);
        check("reset_lo",    lo,    0);
        check("reset_stall", stall, 0);
        @(negedge clk);
        start = 1'b0;
        d_md  = 1'b0;
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, cyc);
            check($sformatf("v%0d_cycles", i), cyc,  vecs[i].e_cyc);
            check($sformatf("v%0d_hi", i),     hi,   vecs[i].e_hi);
            check($sformatf("v%0d_lo", i),     lo,   vecs[i].e_lo);
            check($sformatf("v%0d_busy", i),   busy, 0);
        end

        // Stall held through a divide with d_md=1: 100/7 -> q=14 r=2.
        @(negedge clk);
        d_md = 1'b1; start = 1'b1; md_op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
        #1;
        check("stall_start_cycle", stall, 1);
        @(negedge clk);
        start = 1'b0;
        cyc = 0; ok = 1'b1;
        while (busy === 1'b1 && cyc < 200) begin
            if (stall !== 1'b1) ok = 1'b0;
            cyc++;
            @(negedge clk);
        end
        check("stall_during_busy", ok,    1);
        check("stall_div_cycles",  cyc,   10);
        check("stall_at_fall",     stall, 0);
        check("stall_div_lo",      lo,    14);
        check("stall_div_hi",      hi,    2);

        // Same divide with d_md=0: stall never rises.
        @(negedge clk);
        d_md = 1'b0; start = 1'b1; md_op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
        #1;
        ok = (stall === 1'b0);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            if (stall !== 1'b0) ok = 1'b0;
            cyc++;
            @(negedge clk);
        end
        check("nostall_d_md_low", ok,  1);
        check("nostall_cycles",   cyc, 10);

        // mthi while busy is ignored; operand changes during RUN do not matter.
        @(negedge clk);
        start = 1'b1; md_op = 3'd0; rs_val = 32'd5; rt_val = 32'd7;
        @(negedge clk);
        md_op = 3'd4; rs_val = 32'hABCD; rt_val = 32'h9;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        check("ignore_cycles", cyc, 5);
        check("ignore_hi",     hi,  0);
        check("ignore_lo",     lo,  35);

        run_op(3'd4, 32'hABCD, 32'd0, cyc);
        check("mthi_idle_cycles", cyc, 0);
        check("mthi_idle_hi",     hi,  32'hABCD);
        check("mthi_idle_lo",     lo,  35);

        // Asynchronous reset mid-divide aborts with no HI/LO update.
        @(negedge clk);
        start = 1'b1; md_op = 3'd3; rs_val = 32'd50; rt_val = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_abort_busy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_hi",   hi,   0);
        check("abort_lo",   lo,   0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_late_hi", hi, 0);
        check("abort_no_late_lo", lo, 0);

        run_op(3'd0, 32'hFFFFFFFE, 32'd3, cyc);
        check("post_reset_cycles", cyc, 5);
        check("post_reset_hi",     hi,  32'hFFFFFFFF);
        check("post_reset_lo",     lo,  32'hFFFFFFFA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
